// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle ARM main control FSM.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        ILLEGAL  = 4'd10
    } state_t;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] OP_DP      = 2'b00;
    localparam logic [1:0] OP_MEM     = 2'b01;
    localparam logic [1:0] OP_BR      = 2'b10;

    typedef struct packed {
        logic       irwrite;
        logic       nextpc;
        logic       adrsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic       aluop;
        logic       regw;
        logic       memw;
        logic       branch;
        logic       lsb;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

endpackage

// File: rtl/mc_mainfsm_if.sv
// Instruction-field inputs and datapath control outputs of the main FSM.
interface mc_mainfsm_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       mem_ready;
    logic       IRWrite;
    logic       NextPC;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       ALUOp;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic       LSB;
    logic       instr_done;
    logic       illegal_op;

    // master = the controller driving datapath selects and strobes
    modport master (
        input  Op, Funct, mem_ready,
        output IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
               ALUOp, RegW, MemW, Branch, LSB, instr_done, illegal_op
    );

    modport slave (
        output Op, Funct, mem_ready,
        input  IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
               ALUOp, RegW, MemW, Branch, LSB, instr_done, illegal_op
    );
endinterface

// File: rtl/mc_outdec.sv
// Moore output decoder: state (plus Funct[2] for byte loads) to raw controls.
module mc_outdec
    import mc_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic [STATE_W-1:0] i_state,
    input  logic               i_funct2,
    output ctrl_t              o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            FETCH: begin
                o_ctrl.alusrca   = 1'b1;
                o_ctrl.alusrcb   = SRCB_FOUR;
                o_ctrl.resultsrc = RES_ALU;
                o_ctrl.irwrite   = 1'b1;
                o_ctrl.nextpc    = 1'b1;
            end
            DECODE: begin
                // PC+4 again so R15 reads as PC+8
                o_ctrl.alusrca   = 1'b1;
                o_ctrl.alusrcb   = SRCB_FOUR;
                o_ctrl.resultsrc = RES_ALU;
            end
            MEMADR:   o_ctrl.alusrcb = SRCB_IMM;
            MEMREAD: begin
                o_ctrl.adrsrc    = 1'b1;
                o_ctrl.resultsrc = RES_ALUOUT;
                o_ctrl.lsb       = i_funct2;
            end
            MEMWB: begin
                o_ctrl.resultsrc  = RES_DATA;
                o_ctrl.regw       = 1'b1;
                o_ctrl.lsb        = i_funct2;
                o_ctrl.instr_done = 1'b1;
            end
            MEMWRITE: begin
                o_ctrl.adrsrc     = 1'b1;
                o_ctrl.memw       = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            EXECUTER: begin
                o_ctrl.alusrcb = SRCB_REG;
                o_ctrl.aluop   = 1'b1;
            end
            EXECUTEI: begin
                o_ctrl.alusrcb = SRCB_IMM;
                o_ctrl.aluop   = 1'b1;
            end
            ALUWB: begin
                o_ctrl.resultsrc  = RES_ALUOUT;
                o_ctrl.regw       = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            BRANCH: begin
                o_ctrl.alusrcb    = SRCB_IMM;
                o_ctrl.resultsrc  = RES_ALU;
                o_ctrl.branch     = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            ILLEGAL: begin
                o_ctrl.illegal_op = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_mainfsm.sv
// Multicycle ARM main control FSM. Optional memory wait states: define
// MC_MEM_WAIT_EN to hold FETCH/MEMREAD/MEMWRITE until mem_ready.
module mc_mainfsm
    import mc_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic         clk,
    input  logic         reset,
    mc_mainfsm_if.master bus
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next;
    ctrl_t              w_dec;
    logic               w_go;
    logic               w_unused;

`ifdef MC_MEM_WAIT_EN
    assign w_go = (r_state == FETCH || r_state == MEMREAD || r_state == MEMWRITE)
                  ? bus.mem_ready : 1'b1;
    assign w_unused = ^{bus.Funct[4:3], bus.Funct[1]};
`else
    assign w_go = 1'b1;
    assign w_unused = ^{bus.mem_ready, bus.Funct[4:3], bus.Funct[1]};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            FETCH:    if (w_go) w_next = DECODE;
            DECODE: begin
                case (bus.Op)
                    OP_MEM:  w_next = MEMADR;
                    OP_DP:   w_next = bus.Funct[5] ? EXECUTEI : EXECUTER;
                    OP_BR:   w_next = BRANCH;
                    default: w_next = ILLEGAL;
                endcase
            end
            MEMADR:   w_next = bus.Funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  if (w_go) w_next = MEMWB;
            MEMWRITE: if (w_go) w_next = FETCH;
            EXECUTER, EXECUTEI: w_next = ALUWB;
            MEMWB, ALUWB, BRANCH, ILLEGAL: w_next = FETCH;
            default:  w_next = FETCH;
        endcase
    end

    mc_outdec #(.STATE_W(STATE_W)) u_outdec (
        .i_state  (r_state),
        .i_funct2 (bus.Funct[2]),
        .o_ctrl   (w_dec)
    );

    // Selects pass straight through; strobes are killed during reset, and
    // the PC-advance / completion strobes wait for the memory handshake.
    assign bus.AdrSrc     = w_dec.adrsrc;
    assign bus.ALUSrcA    = w_dec.alusrca;
    assign bus.ALUSrcB    = w_dec.alusrcb;
    assign bus.ResultSrc  = w_dec.resultsrc;
    assign bus.ALUOp      = w_dec.aluop;
    assign bus.LSB        = w_dec.lsb;
    assign bus.IRWrite    = w_dec.irwrite    & w_go & ~reset;
    assign bus.NextPC     = w_dec.nextpc     & w_go & ~reset;
    assign bus.instr_done = w_dec.instr_done & w_go & ~reset;
    assign bus.RegW       = w_dec.regw       & ~reset;
    assign bus.MemW       = w_dec.memw       & ~reset;
    assign bus.Branch     = w_dec.branch     & ~reset;
    assign bus.illegal_op = w_dec.illegal_op & ~reset;

endmodule

// File: tb/tb_mc_mainfsm.sv
// Randomized self-checking bench for mc_mainfsm against a per-instruction
// phase-sequence model; follows MC_MEM_WAIT_EN if it is defined for the build.
`timescale 1ns/1ps
module tb_mc_mainfsm;

    logic clk = 1'b0;
    logic reset = 1'b1;
    mc_mainfsm_if bus();

    mc_mainfsm #(.STATE_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef MC_MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    int n_chk = 0;
    int n_fail = 0;
    string seq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // {IRWrite,NextPC,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUOp,RegW,MemW,Branch,LSB,instr_done,illegal_op}
    function automatic logic [14:0] obs();
        return {bus.IRWrite, bus.NextPC, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB,
                bus.ResultSrc, bus.ALUOp, bus.RegW, bus.MemW, bus.Branch,
                bus.LSB, bus.instr_done, bus.illegal_op};
    endfunction

    localparam logic [14:0] RST_ROW = {2'b00, 1'b0, 1'b1, 2'b10, 2'b10, 7'b0};

    function automatic logic [14:0] row(input string ph, input bit lsb);
        if (ph == "FETCH")    return {2'b11, 1'b0, 1'b1, 2'b10, 2'b10, 7'b0};
        if (ph == "DECODE")   return {2'b00, 1'b0, 1'b1, 2'b10, 2'b10, 7'b0};
        if (ph == "MEMADR")   return {4'b0000, 2'b01, 2'b00, 7'b0};
        if (ph == "MEMREAD")  return {2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 4'b0000, lsb, 2'b00};
        if (ph == "MEMWB")    return {4'b0000, 2'b00, 2'b01, 1'b0, 1'b1, 2'b00, lsb, 1'b1, 1'b0};
        if (ph == "MEMWRITE") return {2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0};
        if (ph == "EXECUTER") return {4'b0000, 2'b00, 2'b00, 1'b1, 6'b0};
        if (ph == "EXECUTEI") return {4'b0000, 2'b01, 2'b00, 1'b1, 6'b0};
        if (ph == "ALUWB")    return {4'b0000, 2'b00, 2'b00, 2'b01, 3'b000, 2'b10};
        if (ph == "BRANCH")   return {4'b0000, 2'b01, 2'b10, 3'b000, 1'b1, 1'b0, 2'b10};
        if (ph == "ILLEGAL")  return {13'b0, 2'b11};
        return 15'h7fff;
    endfunction

    // Phase list an instruction walks through, from its Op/Funct fields.
    task automatic load(input logic [1:0] op, input logic [5:0] fn);
        seq = {};
        seq.push_back("FETCH");
        seq.push_back("DECODE");
        case (op)
            2'b00: begin
                seq.push_back(fn[5] ? "EXECUTEI" : "EXECUTER");
                seq.push_back("ALUWB");
            end
            2'b01: begin
                seq.push_back("MEMADR");
                if (fn[0]) begin
                    seq.push_back("MEMREAD");
                    seq.push_back("MEMWB");
                end else begin
                    seq.push_back("MEMWRITE");
                end
            end
            2'b10:   seq.push_back("BRANCH");
            default: seq.push_back("ILLEGAL");
        endcase
    endtask

    // dir_wait: hold mem_ready low for the first 3 cycles of FETCH and MEMWRITE
    task automatic run_instr(input logic [1:0] op, input logic [5:0] fn, input bit dir_wait);
        int ncyc = 0, ndone = 0, nnpc = 0, nwait = 0, ph_cyc = 0, lat;
        load(op, fn);
        lat = seq.size();
        bus.Op = op;
        bus.Funct = fn;
        while (seq.size() > 0 && ncyc < 200) begin
            bit mr, stall, memph;
            logic [14:0] e;
            string ph;
            ph = seq[0];
            memph = (ph == "FETCH" || ph == "MEMREAD" || ph == "MEMWRITE");
            if (dir_wait && (ph == "FETCH" || ph == "MEMWRITE")) mr = (ph_cyc >= 3);
            else if (WAIT_EN) mr = ($urandom_range(0, 3) != 0);
            else mr = 1'($urandom_range(0, 1));
            bus.mem_ready = mr;
            stall = WAIT_EN && memph && !mr;
            e = row(ph, fn[2]);
            if (stall) begin
                e[14] = 1'b0;
                e[13] = 1'b0;
                e[1]  = 1'b0;
            end
            @(negedge clk);
            chk(ph, 32'(obs()), 32'(e));
            if (bus.instr_done) ndone++;
            if (bus.NextPC) nnpc++;
            if (stall) begin
                nwait++;
                ph_cyc++;
            end else begin
                void'(seq.pop_front());
                ph_cyc = 0;
            end
            ncyc++;
            @(posedge clk);
            #1;
        end
        chk("done_count", ndone, 1);
        chk("nextpc_count", nnpc, 1);
        chk("latency", ncyc, lat + nwait);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("reset_out", 32'(obs()), 32'(RST_ROW));
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    initial begin
        bus.Op = 2'b00;
        bus.Funct = 6'b0;
        bus.mem_ready = 1'b0;
        #1;
        do_reset();

        run_instr(2'b00, 6'b101000, 1'b0);   // ADD imm
        run_instr(2'b01, 6'b011101, 1'b0);   // LDRB
        run_instr(2'b01, 6'b011001, 1'b0);   // LDR
        run_instr(2'b01, 6'b011000, 1'b0);   // STR
        run_instr(2'b10, 6'b100000, 1'b0);   // B
        run_instr(2'b11, 6'b000000, 1'b0);   // illegal
        run_instr(2'b00, 6'b001000, 1'b0);   // ADD reg
        run_instr(2'b01, 6'b011000, 1'b1);   // STR with forced memory waits

        // reset in the middle of an LDR abandons it
        bus.Op = 2'b01;
        bus.Funct = 6'b011001;
        bus.mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        run_instr(2'b10, 6'b000000, 1'b0);

        for (int i = 0; i < 80; i++) begin
            logic [1:0] op;
            logic [5:0] fn;
            op = 2'($urandom_range(0, 3));
            fn = 6'($urandom);
            run_instr(op, fn, ($urandom_range(0, 9) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mc_mainfsm.md
Name: mc_mainfsm

Overview:
- Main control state machine for a multicycle ARM core, the next step after the single-cycle core. It reuses the existing ALU, regfile, extend and condlogic blocks.
- Sequences one shared ALU and one unified instruction/data memory over 3–5 cycles per instruction.
- Produces Moore-style datapath selects and unconditional write strobes. These strobes (RegW, MemW, Branch, NextPC) then pass through condlogic gating, exactly as the single-cycle decoder outputs do.
- Supported instructions: DP reg/imm, LDR, LDRB, STR and B.

Parameters:
- STATE_W, 4, width of the state register. It must hold the 11 states.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- Op  in  2  Instr[27:26], taken from the instruction register and stable after FETCH.
- Funct  in  6  Instr[25:20], from the instruction register.
- mem_ready  in  1  memory completion. Used only when MC_MEM_WAIT_EN is defined.
- IRWrite  out  1  load the instruction register.
- NextPC  out  1  PC write enable (PC <= ALUResult).
- AdrSrc  out  1  0 selects PC as memory address, 1 selects ALUOut.
- ALUSrcA  out  1  0 selects register A, 1 selects PC.
- ALUSrcB  out  2  00 WriteData register, 01 ExtImm, 10 constant 4.
- ResultSrc  out  2  00 ALUOut, 01 Data register, 10 ALUResult.
- ALUOp  out  1  1 means the ALU decoder uses Funct; 0 forces ADD.
- RegW  out  1  unconditional register write strobe.
- MemW  out  1  unconditional memory write strobe.
- Branch  out  1  branch strobe.
- LSB  out  1  byte load select.
- instr_done  out  1  pulses in the last cycle of each instruction.
- illegal_op  out  1  pulses when Op == 11 is decoded.

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, ILLEGAL.
- Reset: the state goes to FETCH asynchronously. While reset is high, IRWrite, NextPC, RegW, MemW, Branch, instr_done and illegal_op are forced to 0, and the selects take their FETCH values.
- Outputs are a function of state only (Moore), except for the mem_ready qualification when the macro is defined. Any output not listed for a state is 0.
  - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, IRWrite=1, NextPC=1.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. This lets R15 read as PC+8.
  - MEMADR: ALUSrcA=0, ALUSrcB=01.
  - MEMREAD: AdrSrc=1, ResultSrc=00, LSB=Funct[2].
  - MEMWB: ResultSrc=01, RegW=1, LSB=Funct[2], instr_done=1.
  - MEMWRITE: AdrSrc=1, MemW=1, instr_done=1.
  - EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1, instr_done=1.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1, instr_done=1.
  - ILLEGAL: illegal_op=1, instr_done=1. No strobes.
- Transitions:
  - FETCH goes to DECODE.
  - DECODE branches on Op:
    - Op=01 goes to MEMADR.
    - Op=00 with Funct[5]=1 goes to EXECUTEI; Op=00 with Funct[5]=0 goes to EXECUTER.
    - Op=10 goes to BRANCH.
    - Op=11 goes to ILLEGAL.
  - MEMADR goes to MEMREAD if Funct[0]=1, else MEMWRITE.
  - MEMREAD goes to MEMWB.
  - EXECUTER and EXECUTEI go to ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BRANCH and ILLEGAL go to FETCH.
  - Any unreachable state encoding goes to FETCH.
- Latency in cycles, without wait states:
  - B = 3.
  - STR = 4.
  - DP = 4.
  - LDR/LDRB = 5.
  - Illegal = 3.
- instr_done is high for exactly one cycle per instruction.
- A write to PC through Rd=15 relies on condlogic's PCS path; this block only asserts RegW.
- Reset mid-instruction abandons the instruction. No strobe is asserted in the cycle after reset deasserts, other than the FETCH strobes.

Optional Feature:
- Macro: MC_MEM_WAIT_EN.
- When defined:
  - FETCH, MEMREAD and MEMWRITE hold state while mem_ready=0.
  - In FETCH, IRWrite and NextPC are asserted only in the cycle with mem_ready=1, so PC advances exactly once per fetch.
  - MemW stays high for all of MEMWRITE; instr_done is asserted only in its mem_ready=1 cycle.
  - mem_ready is sampled only in those three states.
- When undefined: mem_ready is ignored, the port remains, and every memory access takes one cycle.

Decomposition:
- Package mc_pkg holds:
  - the state_t enum, encoded 0–10 with FETCH=0;
  - the ALUSrcB encodings SRCB_REG, SRCB_IMM, SRCB_FOUR;
  - the ResultSrc encodings RES_ALUOUT, RES_DATA, RES_ALU;
  - the Op encodings OP_DP, OP_MEM, OP_BR.
- One sub-module, mc_outdec: a purely combinational decoder from state plus Funct[2] to outputs. The FSM instantiates it and applies the reset and mem_ready qualification.

Test Plan:
1. Reset high for 2 cycles, then released -> strobes 0 during reset. The first cycle after release is FETCH with IRWrite=NextPC=1. The second cycle is DECODE.
2. ADD imm (Op=00, Funct=101000) -> the state sequence is FETCH, DECODE, EXECUTEI, ALUWB. ALUOp=1 in EXECUTEI. RegW=1 and instr_done=1 only in cycle 4.
3. LDRB (Op=01, Funct=011101) -> MEMADR (ALUSrcB=01), MEMREAD (AdrSrc=1, LSB=1), MEMWB (ResultSrc=01, RegW=1). Total 5 cycles. For LDR (Funct=011001), LSB=0.
4. STR followed by B -> STR takes 4 cycles with MemW=1 only in MEMWRITE. B takes 3 cycles with Branch=1 and ResultSrc=10 in BRANCH.
5. Op=11 -> DECODE, then ILLEGAL with illegal_op=1 and no RegW or MemW, then FETCH.
6. With MC_MEM_WAIT_EN defined, mem_ready low for 3 cycles in FETCH and MEMWRITE -> the state holds. NextPC is pulsed once; MemW stays high 4 cycles; instr_done is asserted once.
